// File: rtl/ecdsa_pkg.sv
// Shared encodings for the ECDSA DMA sequencer: FSM states, CPU command codes
// and the bit layout of the status word.
package ecdsa_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RX      = 4'd1,
        ST_RX_WAIT = 4'd2,
        ST_CSTART  = 4'd3,
        ST_CWAIT   = 4'd4,
        ST_TX      = 4'd5,
        ST_TX_WAIT = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERR     = 4'd8
    } state_t;

    localparam logic [31:0] CMD_IDLE   = 32'd0;
    localparam logic [31:0] CMD_FULL   = 32'd1;
    localparam logic [31:0] CMD_REUSE  = 32'd2;
    localparam logic [31:0] CMD_TXONLY = 32'd3;

    localparam int STAT_FINISHED = 0;   // DONE or ERR
    localparam int STAT_IDLE     = 1;
    localparam int STAT_ERR_DMA  = 2;
    localparam int STAT_ERR_TMO  = 3;
    localparam int STAT_STATE    = 8;   // 4-bit field
    localparam int STAT_IDX      = 12;  // 4-bit field

endpackage

// File: rtl/ecdsa_dma_port.sv
// One DMA direction: start request handshake, strided word address,
// done/error qualification and the wait watchdog.
module ecdsa_dma_port
    import ecdsa_pkg::*;
#(
    parameter int ADDR_STRIDE = 128,
    parameter int TMO_W       = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wait_en,
    input  logic        tmo_en,
    input  logic [31:0] base,
    input  logic [3:0]  idx,
    input  logic        dma_idle,
    input  logic        dma_done,
    input  logic        dma_error,
    output logic        start,
    output logic [31:0] address,
    output logic        accepted,
    output logic        done,
    output logic        error,
    output logic        expired
);

    localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    logic [TMO_W-1:0] tmo_cnt;

    // Request is raised the cycle after entering the request state and dropped
    // once the DMA leaves idle, i.e. it has taken the request.
    assign accepted = req && start && !dma_idle;
    assign error    = (req || wait_en) && dma_error;
    assign done     = wait_en && dma_done && !dma_error;
    assign expired  = tmo_en && (tmo_cnt == TMO_LAST);
    assign address  = base + 32'(idx) * 32'(ADDR_STRIDE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            start <= 1'b0;
        end else begin
            start <= req && !accepted && !dma_error;
        end
    end

    // The wait states never follow each other directly, so leaving the enable
    // low for a cycle is enough to clear the count on every state change.
    always_ff @(posedge clk) begin
        if (!resetn || !tmo_en) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ecdsa_dma_sequencer.sv
// Command sequencer: DMA-fetches the operand bank, runs the ECDSA core and
// DMA-writes the result bank back, with a watchdog and sticky error state.
module ecdsa_dma_sequencer
    import ecdsa_pkg::*;
#(
    parameter int DATA_W      = 381,
    parameter int N_RX        = 4,
    parameter int N_TX        = 2,
    parameter int ADDR_STRIDE = 128,
    parameter int TMO_W       = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [31:0]            command,
    input  logic [31:0]            rx_base,
    input  logic [31:0]            tx_base,
    output logic [31:0]            status,
    input  logic [DATA_W-1:0]      dma_rx_data,
    output logic [31:0]            dma_rx_address,
    output logic                   dma_rx_start,
    output logic [DATA_W-1:0]      dma_tx_data,
    output logic [31:0]            dma_tx_address,
    output logic                   dma_tx_start,
    input  logic                   dma_done,
    input  logic                   dma_idle,
    input  logic                   dma_error,
    output logic                   core_start,
    output logic [N_RX*DATA_W-1:0] core_operands,
    input  logic                   core_done,
    input  logic [N_TX*DATA_W-1:0] core_result
);

    state_t                         state;
    logic [3:0]                     idx;
    logic                           err_dma;
    logic                           err_tmo;
    logic [N_RX-1:0][DATA_W-1:0]    op_bank;
    logic [N_TX-1:0][DATA_W-1:0]    res_bank;
    logic [DATA_W-1:0]              tx_word;
    logic rx_accepted, rx_done, rx_error, rx_expired;
    logic tx_accepted, tx_done, tx_error, tx_expired;

    ecdsa_dma_port #(.ADDR_STRIDE(ADDR_STRIDE), .TMO_W(TMO_W)) u_rx (
        .clk(clk), .resetn(resetn),
        .req(state == ST_RX), .wait_en(state == ST_RX_WAIT), .tmo_en(state == ST_RX_WAIT),
        .base(rx_base), .idx(idx),
        .dma_idle(dma_idle), .dma_done(dma_done), .dma_error(dma_error),
        .start(dma_rx_start), .address(dma_rx_address), .accepted(rx_accepted),
        .done(rx_done), .error(rx_error), .expired(rx_expired)
    );

    // The core wait is guarded by the tx watchdog: the result feeds the tx path.
    ecdsa_dma_port #(.ADDR_STRIDE(ADDR_STRIDE), .TMO_W(TMO_W)) u_tx (
        .clk(clk), .resetn(resetn),
        .req(state == ST_TX), .wait_en(state == ST_TX_WAIT),
        .tmo_en(state == ST_TX_WAIT || state == ST_CWAIT),
        .base(tx_base), .idx(idx),
        .dma_idle(dma_idle), .dma_done(dma_done), .dma_error(dma_error),
        .start(dma_tx_start), .address(dma_tx_address), .accepted(tx_accepted),
        .done(tx_done), .error(tx_error), .expired(tx_expired)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            idx        <= '0;
            core_start <= 1'b0;
            err_dma    <= 1'b0;
            err_tmo    <= 1'b0;
            res_bank   <= '0;
        end else begin
            core_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    case (command)
                        CMD_FULL:   begin state <= ST_RX; idx <= '0; end
                        CMD_REUSE:  state <= ST_CSTART;
                        CMD_TXONLY: begin state <= ST_TX; idx <= '0; end
                        default: ;
                    endcase
                end
                ST_RX:      if (rx_accepted) state <= ST_RX_WAIT;
                ST_RX_WAIT: if (rx_done) begin
                    if (idx == 4'(N_RX - 1)) begin
                        state <= ST_CSTART;
                    end else begin
                        idx   <= idx + 4'd1;
                        state <= ST_RX;
                    end
                end
                ST_CSTART: begin
                    core_start <= 1'b1;
                    state      <= ST_CWAIT;
                end
                ST_CWAIT: if (core_done) begin
                    res_bank <= core_result;
                    idx      <= '0;
                    state    <= ST_TX;
                end
                ST_TX:      if (tx_accepted) state <= ST_TX_WAIT;
                ST_TX_WAIT: if (tx_done) begin
                    if (idx == 4'(N_TX - 1)) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 4'd1;
                        state <= ST_TX;
                    end
                end
                ST_DONE: if (command == CMD_IDLE) begin
                    state <= ST_IDLE;
                    idx   <= '0;
                end
                ST_ERR: if (command == CMD_IDLE) begin
                    state   <= ST_IDLE;
                    idx     <= '0;
                    err_dma <= 1'b0;
                    err_tmo <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase

            // Faults override whatever the state logic chose this cycle.
            if (rx_error || tx_error) begin
                state   <= ST_ERR;
                err_dma <= 1'b1;
            end else if (rx_expired || tx_expired) begin
                state   <= ST_ERR;
                err_tmo <= 1'b1;
            end
        end
    end

    // NOTE: the operand bank is deliberately left out of reset so a reuse
    // command can still see operands loaded before a reset.
    always_ff @(posedge clk) begin
        if (rx_done) begin
            for (int i = 0; i < N_RX; i++) begin
                if (idx == 4'(i)) op_bank[i] <= dma_rx_data;
            end
        end
    end

    // NOTE: combinational outputs get a default first so no path infers a latch.
    always_comb begin
        tx_word = '0;
        for (int i = 0; i < N_TX; i++) begin
            if (idx == 4'(i)) tx_word = res_bank[i];
        end
    end

    always_comb begin
        status                     = '0;
        status[STAT_IDX +: 4]      = idx;
        status[STAT_STATE +: 4]    = state;
        status[STAT_ERR_TMO]       = err_tmo;
        status[STAT_ERR_DMA]       = err_dma;
        status[STAT_IDLE]          = (state == ST_IDLE);
        status[STAT_FINISHED]      = (state == ST_DONE) || (state == ST_ERR);
    end

    assign dma_tx_data   = tx_word;
    assign core_operands = op_bank;

endmodule

// File: tb/tb_ecdsa_dma_sequencer.sv
// Self-checking bench: behavioural DMA and core models with address/data
// scoreboards, driven one negedge at a time from a single process.
module tb_ecdsa_dma_sequencer;
    import ecdsa_pkg::*;

    localparam int DATA_W      = 381;
    localparam int N_RX        = 4;
    localparam int N_TX        = 2;
    localparam int ADDR_STRIDE = 128;
    localparam int TMO_W       = 4;
    localparam int DMA_LAT     = 5;
    localparam int CORE_LAT    = 3;

    typedef logic [383:0]       val_t;
    typedef logic [DATA_W-1:0]  word_t;

    logic                   clk = 1'b0;
    logic                   resetn;
    logic [31:0]            command, rx_base, tx_base, status;
    logic [DATA_W-1:0]      dma_rx_data, dma_tx_data;
    logic [31:0]            dma_rx_address, dma_tx_address;
    logic                   dma_rx_start, dma_tx_start, dma_done, dma_idle, dma_error;
    logic                   core_start, core_done;
    logic [N_RX*DATA_W-1:0] core_operands;
    logic [N_TX*DATA_W-1:0] core_result;

    ecdsa_dma_sequencer #(
        .DATA_W(DATA_W), .N_RX(N_RX), .N_TX(N_TX),
        .ADDR_STRIDE(ADDR_STRIDE), .TMO_W(TMO_W)
    ) dut (
        .clk(clk), .resetn(resetn), .command(command),
        .rx_base(rx_base), .tx_base(tx_base), .status(status),
        .dma_rx_data(dma_rx_data), .dma_rx_address(dma_rx_address), .dma_rx_start(dma_rx_start),
        .dma_tx_data(dma_tx_data), .dma_tx_address(dma_tx_address), .dma_tx_start(dma_tx_start),
        .dma_done(dma_done), .dma_idle(dma_idle), .dma_error(dma_error),
        .core_start(core_start), .core_operands(core_operands),
        .core_done(core_done), .core_result(core_result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Scoreboards: filled when a command is issued, drained by the DMA model.
    logic [31:0] exp_rx_addr[$];
    logic [31:0] exp_tx_addr[$];
    word_t       exp_txd[$];
    word_t       rx_feed[$];
    word_t       bank_exp[N_RX];
    word_t       res_exp[N_TX];

    int    dma_cnt, core_cnt, rx_seen, fault_idx;
    int    n_rx_start, n_tx_start, n_core_start;
    logic  fault_both, core_hold, cur_fault, cur_is_rx;
    word_t cur_word;

    task automatic check(input string tag, input val_t obs, input val_t exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t make_word(input int unsigned seed);
        logic [383:0] w;
        for (int k = 0; k < 12; k++) w[k*32 +: 32] = (seed * 32'h9E37_79B9) ^ (32'(k) << 24) ^ 32'(k);
        return w[DATA_W-1:0];
    endfunction

    function automatic word_t core_fn(input word_t a, input word_t b);
        return ~(a ^ b);
    endfunction

    // One clock of the environment: DMA model, core model and start counters.
    task automatic tick();
        @(negedge clk);
        dma_done  = 1'b0;
        dma_error = 1'b0;
        core_done = 1'b0;
        if (!resetn) begin
            dma_cnt  = 0;
            dma_idle = 1'b1;
            core_cnt = 0;
            return;
        end
        if (dma_rx_start) n_rx_start++;
        if (dma_tx_start) n_tx_start++;
        if (core_start)   n_core_start++;

        if (dma_cnt > 0) begin
            dma_cnt--;
            if (dma_cnt == 0) begin
                dma_idle = 1'b1;
                if (cur_fault) begin
                    dma_error = 1'b1;
                    dma_done  = fault_both;
                end else begin
                    dma_done = 1'b1;
                end
                if (cur_is_rx) dma_rx_data = cur_word;
                else if (exp_txd.size() == 0) check("tx_data_unexpected", val_t'(exp_txd.size()), val_t'(1));
                else check("tx_data", val_t'(dma_tx_data), val_t'(exp_txd.pop_front()));
            end
        end else if (dma_rx_start) begin
            cur_is_rx = 1'b1;
            dma_idle  = 1'b0;
            dma_cnt   = DMA_LAT;
            rx_seen++;
            cur_fault = (fault_idx != 0) && (rx_seen == fault_idx);
            if (rx_feed.size() > 0) cur_word = rx_feed.pop_front();
            else cur_word = '0;
            if (exp_rx_addr.size() == 0) check("rx_addr_unexpected", val_t'(exp_rx_addr.size()), val_t'(1));
            else check("rx_addr", val_t'(dma_rx_address), val_t'(exp_rx_addr.pop_front()));
        end else if (dma_tx_start) begin
            cur_is_rx = 1'b0;
            cur_fault = 1'b0;
            dma_idle  = 1'b0;
            dma_cnt   = DMA_LAT;
            if (exp_tx_addr.size() == 0) check("tx_addr_unexpected", val_t'(exp_tx_addr.size()), val_t'(1));
            else check("tx_addr", val_t'(dma_tx_address), val_t'(exp_tx_addr.pop_front()));
        end

        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                core_done = 1'b1;
                for (int j = 0; j < N_TX; j++)
                    core_result[j*DATA_W +: DATA_W] = core_fn(core_operands[j*DATA_W +: DATA_W],
                                                              core_operands[(j+N_TX)*DATA_W +: DATA_W]);
            end
        end else if (core_start && !core_hold) begin
            core_cnt = CORE_LAT;
        end
    endtask

    task automatic wait_finished(input string tag);
        int n = 0;
        while (status[STAT_FINISHED] !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        check({tag, "_finished"}, val_t'(status[STAT_FINISHED]), val_t'(1));
    endtask

    task automatic release_cmd(input string tag);
        command = CMD_IDLE;
        tick();
        tick();
        check({tag, "_released"}, val_t'(status[3:0]), val_t'(4'b0010));
    endtask

    // rx words: n_feed fetched by DMA, the first n_latch expected in the bank.
    task automatic push_rx(input int unsigned seed, input int n_feed, input int n_latch);
        for (int i = 0; i < n_feed; i++) begin
            word_t w = make_word(seed + i);
            rx_feed.push_back(w);
            exp_rx_addr.push_back(rx_base + 32'(i * ADDR_STRIDE));
            if (i < n_latch) bank_exp[i] = w;
        end
    endtask

    task automatic push_compute_tx();
        for (int j = 0; j < N_TX; j++) begin
            res_exp[j] = core_fn(bank_exp[j], bank_exp[j + N_TX]);
            exp_tx_addr.push_back(tx_base + 32'(j * ADDR_STRIDE));
            exp_txd.push_back(res_exp[j]);
        end
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < N_RX; i++)
            check($sformatf("%s_op%0d", tag, i), val_t'(core_operands[i*DATA_W +: DATA_W]), val_t'(bank_exp[i]));
    endtask

    initial begin
        int rx0, tx0, cs0, n, ncw;
        resetn = 1'b0; command = CMD_IDLE; rx_base = '0; tx_base = '0;
        dma_rx_data = '0; dma_done = 1'b0; dma_idle = 1'b1; dma_error = 1'b0;
        core_done = 1'b0; core_result = '0; core_hold = 1'b0;
        dma_cnt = 0; core_cnt = 0; rx_seen = 0; fault_idx = 0; fault_both = 1'b0;
        cur_fault = 1'b0; cur_is_rx = 1'b0; cur_word = '0;
        n_rx_start = 0; n_tx_start = 0; n_core_start = 0;
        for (int i = 0; i < N_RX; i++) bank_exp[i] = '0;

        repeat (3) tick();
        check("reset_status", val_t'(status), val_t'(32'h0000_0002));
        check("reset_rx_start", val_t'(dma_rx_start), val_t'(0));
        check("reset_tx_start", val_t'(dma_tx_start), val_t'(0));
        check("reset_core_start", val_t'(core_start), val_t'(0));
        resetn = 1'b1;
        tick();

        // Full run with strided addresses.
        rx_base = 32'h0000_1000; tx_base = 32'h0000_2000;
        push_rx(10, N_RX, N_RX);
        push_compute_tx();
        rx0 = n_rx_start; tx0 = n_tx_start; cs0 = n_core_start;
        command = CMD_FULL;
        wait_finished("m1");
        check("m1_status", val_t'(status), val_t'(32'h0000_1701));
        check_bank("m1");
        check("m1_rx_pulses", val_t'(n_rx_start - rx0), val_t'(N_RX));
        check("m1_tx_pulses", val_t'(n_tx_start - tx0), val_t'(N_TX));
        check("m1_core_pulses", val_t'(n_core_start - cs0), val_t'(1));
        repeat (3) tick();
        check("m1_status_hold", val_t'(status), val_t'(32'h0000_1701));
        release_cmd("m1");

        // Reuse the operand bank: compute and transmit only.
        push_compute_tx();
        rx0 = n_rx_start; cs0 = n_core_start;
        command = CMD_REUSE;
        wait_finished("m2");
        check("m2_status", val_t'(status), val_t'(32'h0000_1701));
        check("m2_rx_pulses", val_t'(n_rx_start - rx0), val_t'(0));
        check("m2_core_pulses", val_t'(n_core_start - cs0), val_t'(1));
        check_bank("m2");
        release_cmd("m2");

        // DMA error on the third operand word.
        push_rx(20, 3, 2);
        rx_seen = 0; fault_idx = 3; fault_both = 1'b0;
        cs0 = n_core_start;
        command = CMD_FULL;
        wait_finished("err");
        check("err_status", val_t'(status), val_t'(32'h0000_2805));
        check("err_core_pulses", val_t'(n_core_start - cs0), val_t'(0));
        check_bank("err");
        release_cmd("err");
        fault_idx = 0;

        // Core never answers: watchdog expiry in CWAIT.
        core_hold = 1'b1;
        n = 0; ncw = 0;
        command = CMD_REUSE;
        do begin
            tick();
            n++;
            if (status[11:8] == ST_CWAIT) ncw++;
        end while (status[11:8] != ST_ERR && n < 100);
        check("tmo_cwait_cycles", val_t'(ncw), val_t'(15));
        check("tmo_status", val_t'(status[11:0]), val_t'(12'h809));
        release_cmd("tmo");
        core_hold = 1'b0;

        // dma_done and dma_error together on the second word: error wins.
        push_rx(30, 2, 1);
        rx_seen = 0; fault_idx = 2; fault_both = 1'b1;
        command = CMD_FULL;
        wait_finished("both");
        check("both_status", val_t'(status), val_t'(32'h0000_1805));
        check_bank("both");
        release_cmd("both");
        fault_idx = 0;

        // Tx-only with address wrap; result bank still holds the last core result.
        tx_base = 32'hFFFF_FFC0;
        exp_tx_addr.push_back(32'hFFFF_FFC0);
        exp_tx_addr.push_back(32'h0000_0040);
        for (int j = 0; j < N_TX; j++) exp_txd.push_back(res_exp[j]);
        rx0 = n_rx_start; tx0 = n_tx_start; cs0 = n_core_start;
        command = CMD_TXONLY;
        wait_finished("m3");
        check("m3_status", val_t'(status), val_t'(32'h0000_1701));
        check("m3_tx_pulses", val_t'(n_tx_start - tx0), val_t'(N_TX));
        check("m3_rx_core_pulses", val_t'((n_rx_start - rx0) + (n_core_start - cs0)), val_t'(0));
        release_cmd("m3");

        // Reset while waiting for a tx completion.
        tx_base = 32'h0000_3000;
        exp_tx_addr.push_back(32'h0000_3000);
        command = CMD_TXONLY;
        n = 0;
        while (status[11:8] != ST_TX_WAIT && n < 100) begin
            tick();
            n++;
        end
        check("rst_reached_tx_wait", val_t'(status[11:8]), val_t'(ST_TX_WAIT));
        resetn = 1'b0;
        command = CMD_IDLE;
        tick();
        check("rst_status", val_t'(status), val_t'(32'h0000_0002));
        check("rst_tx_start", val_t'(dma_tx_start), val_t'(0));
        resetn = 1'b1;
        tick();

        // Result bank is cleared by reset.
        tx_base = 32'h0000_4000;
        for (int j = 0; j < N_TX; j++) begin
            exp_tx_addr.push_back(tx_base + 32'(j * ADDR_STRIDE));
            exp_txd.push_back('0);
        end
        command = CMD_TXONLY;
        wait_finished("post_rst");
        check("post_rst_status", val_t'(status), val_t'(32'h0000_1701));
        release_cmd("post_rst");

        check("sb_empty", val_t'(exp_rx_addr.size() + exp_tx_addr.size() + exp_txd.size()), val_t'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
